// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
//            One quotient bit per clock; results are sign-corrected after the
//            last iteration and held until the requester drops start_i.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous reset, active low
//            signed_div_i - 1 = signed (DIV), 0 = unsigned (DIVU)
//            opdata1_i    - dividend
//            opdata2_i    - divisor
//            start_i      - divide request (level, held until ready_o)
//            annul_i      - cancel the current operation
//            result_o     - {remainder, quotient}, registered
//            ready_o      - result valid, registered
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int c_CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_BYZERO = 2'd1;
    localparam logic [1:0] c_ON     = 2'd2;
    localparam logic [1:0] c_END    = 2'd3;

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W);

    logic [1:0]            r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,     w_cnt_nxt;
    logic [2*DATA_W:0]     r_work,    w_work_nxt;
    logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
    logic                  r_neg1,    w_neg1_nxt;
    logic                  r_neg2,    w_neg2_nxt;
    logic [2*DATA_W-1:0]   r_result,  w_result_nxt;
    logic                  r_ready,   w_ready_nxt;

    logic                  w_op1_neg;
    logic                  w_op2_neg;
    logic [DATA_W-1:0]     w_op1_mag;
    logic [DATA_W-1:0]     w_op2_mag;
    logic [DATA_W:0]       w_trial;
    logic [DATA_W-1:0]     w_rem;
    logic [DATA_W-1:0]     w_quo;
    logic [DATA_W-1:0]     w_rem_fix;
    logic [DATA_W-1:0]     w_quo_fix;

    // Sign flags already fold in signedness, so unsigned operands are never
    // corrected.
    assign w_op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign w_op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign w_op1_mag = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_op2_mag = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Working register layout: [2W:W] is the partial remainder with the next
    // dividend bit already shifted in; the low bits carry the remaining
    // dividend bits and collect quotient bits from bit 0 upward. The partial
    // remainder is always below 2*divisor, so a (W+1)-bit difference never
    // overflows and its MSB is a reliable sign.
    assign w_trial = r_work[2*DATA_W:DATA_W] - {1'b0, r_divisor};

    // After the last iteration the remainder sits one bit above the middle.
    assign w_rem     = r_work[2*DATA_W:DATA_W+1];
    assign w_quo     = r_work[DATA_W-1:0];
    assign w_rem_fix = r_neg1 ? (~w_rem + 1'b1) : w_rem;
    assign w_quo_fix = (r_neg1 ^ r_neg2) ? (~w_quo + 1'b1) : w_quo;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_neg1_nxt    = r_neg1;
        w_neg2_nxt    = r_neg2;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        case (r_state)
            c_FREE: begin
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
                if (start_i && !annul_i) begin
                    w_neg1_nxt    = w_op1_neg;
                    w_neg2_nxt    = w_op2_neg;
                    w_divisor_nxt = w_op2_mag;
                    w_cnt_nxt     = '0;
                    w_work_nxt    = {{DATA_W{1'b0}}, w_op1_mag, 1'b0};
                    w_state_nxt   = (opdata2_i == '0) ? c_BYZERO : c_ON;
                end
            end

            c_BYZERO: begin
                w_result_nxt = '0;
                if (annul_i) begin
                    w_state_nxt = c_FREE;
                    w_ready_nxt = 1'b0;
                end else begin
                    w_state_nxt = c_END;
                    w_ready_nxt = 1'b1;
                end
            end

            c_ON: begin
                if (annul_i) begin
                    w_state_nxt  = c_FREE;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end else if (r_cnt != c_LAST) begin
                    if (w_trial[DATA_W]) begin
                        w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
                    end else begin
                        w_work_nxt = {w_trial[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end else begin
                    w_result_nxt = {w_rem_fix, w_quo_fix};
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = c_END;
                end
            end

            c_END: begin
                if (annul_i || !start_i) begin
                    w_state_nxt  = c_FREE;
                    w_result_nxt = '0;
                    w_ready_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt  = c_FREE;
                w_result_nxt = '0;
                w_ready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_FREE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg1    <= 1'b0;
            r_neg2    <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_neg1    <= w_neg1_nxt;
            r_neg2    <= w_neg2_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: directed corner cases, annul,
//            asynchronous reset, and randomized divides against an arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: language-level division (truncates toward zero, remainder
    // takes the dividend's sign), reduced modulo 2^32.
    function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits edge by edge (sampling 1 ns after each edge) until ready_o, with
    // a cycle budget; returns the number of edges seen.
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_o && n < 100);
    endtask

    // Entered 1 ns after an edge with the DUT idle; leaves it idle the same way.
    task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int n;
        int lat;
        lat = (b == 32'd0) ? 2 : 34;
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        wait_ready(n);
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_result"}, result_o, exp);
        // operands wander while start is held; the result must not move
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sg;
        @(posedge clk);
        #1;
        chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_hold_result"}, result_o, exp);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk({tag, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        int          n;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;

        rst          = 1'b0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;

        #2;
        chk("reset_ready", 64'(ready_o), 64'd0);
        chk("reset_result", result_o, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", 64'(ready_o), 64'd0);

        // Directed cases
        do_div("u_100_7",   1'b0, 32'd100,        32'd7,        {32'd2, 32'd14});
        do_div("s_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD});
        do_div("s_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
        do_div("byzero",    1'b0, 32'h12345678,   32'd0,        64'd0);
        do_div("s_min_m1",  1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0, 32'h80000000});
        do_div("u_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0, 32'hFFFFFFFF});
        do_div("u_nosign",  1'b0, 32'hFFFFFFF9,   32'd2,        {32'd1, 32'h7FFFFFFC});
        do_div("u_bigdiv",  1'b0, 32'hFFFFFFFF,   32'h80000001, {32'h7FFFFFFE, 32'd1});
        do_div("zero_dvd",  1'b1, 32'd0,          32'd5,        64'd0);

        // Annul 10 edges into ON, then a fresh divide right after
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_result", result_o, 64'd0);
        do_div("after_annul", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});

        // Asynchronous reset 20 edges into ON
        signed_div_i = 1'b0;
        opdata1_i    = 32'd123456;
        opdata2_i    = 32'd789;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_on_ready", 64'(ready_o), 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_div("after_rst", 1'b0, 32'd9, 32'd4, {32'd1, 32'd2});

        // Asynchronous reset while a result is being held
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        wait_ready(n);
        chk("rst_end_pre", result_o, {32'd6, 32'd142});
        #2;
        rst = 1'b0;
        #1;
        chk("rst_end_ready", 64'(ready_o), 64'd0);
        chk("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized divides against the reference model
        for (int i = 0; i < 12; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 20));
                1: b = -32'($urandom_range(1, 20));
                2: if (i == 5) b = 32'd0;
                default: ;
            endcase
            do_div($sformatf("rand%0d", i), sg, a, b, ref_div(sg, a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider serving DIV/DIVU in the EX stage.
- EX asserts start_i and holds the pipeline stall request until ready_o is high.
- EX then forwards result_o as ex_hi (remainder) and ex_lo (quotient), with ex_whilo set, into the EX/MEM register.
- annul_i lets EX cancel an in-flight divide on a flush.

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W; iteration counter is clog2(DATA_W)+1 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset: asserted when 0, released synchronously to clk.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  divide request, level; EX holds it until it sees ready_o.
- annul_i  input  1  cancel the current operation.
- result_o  output  2*DATA_W  {remainder, quotient}, registered.
- ready_o  output  1  result valid, registered.

Behaviour:
- Reset (rst=0, async): state=FREE, counter=0, working register=0, result_o=0, ready_o=0.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1 and annul_i=0: latch operands, signedness and sign bits.
  - Divisor==0: next state BYZERO.
  - Otherwise: load magnitudes (two's-complement absolute value if signed and MSB set), counter=0, next state ON.
  - Else: stay in FREE with ready_o=0 and result_o=0.
  - Operand changes after acceptance are ignored.
- BYZERO: next edge goes to END with result_o=0 and ready_o=1.
- ON, annul_i=1: go to FREE; result_o=0, ready_o=0; partial result discarded.
- ON, annul_i=0, counter<DATA_W: one iteration per edge on the (2*DATA_W+1)-bit working register {rem, quo}:
  - trial = rem − {0, divisor}.
  - trial negative: shift left, inserting 0.
  - trial non-negative: rem←trial, shift left, inserting 1.
  - counter++.
- ON, counter==DATA_W:
  - Quotient is negated if signed and dividend sign ≠ divisor sign.
  - Remainder is negated if signed and dividend negative.
  - result_o={rem, quo}, ready_o=1, next state END.
- Latency:
  - Start accepted at edge E0.
  - Iterations on E1..E32.
  - ready_o first high after E33, i.e. 34 edges after start_i is first sampled, for a nonzero divisor.
  - Divide by zero: ready_o high after E1.
- END: hold result_o and ready_o while start_i=1. When start_i=0: go to FREE, ready_o=0, result_o=0.
- annul_i in END or BYZERO: go to FREE and clear the outputs.
- start_i while in ON/BYZERO/END does not restart the operation.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wraps, no trap).
  - Unsigned operands are never sign-corrected.
  - Dividend 0 gives {0, 0} after full latency.
- Reset mid-operation: immediate return to FREE with all outputs 0; no result is produced for the interrupted divide.
- Widths: all arithmetic is modulo 2^DATA_W. Negation is two's complement.

Test Plan:
- Unsigned 100/7: start_i=1 with signed_div_i=0 -> ready_o rises 34 edges after start is sampled, result_o={32'd2, 32'd14}, held until start_i drops, then 0 one edge later.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/−2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero: 0x12345678 / 0 -> ready_o high after 2 edges, result_o=0. Corner cases:
  - Signed 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Annul: assert annul_i for one cycle, 10 edges into ON -> FREE, ready_o never rises. A new start on the next cycle (50/5) -> {0, 10} with full latency.
- Reset mid-op: drive rst=0 asynchronously, between clock edges, 20 edges into ON -> result_o and ready_o are 0 immediately, before the next edge. After release, a new start (9/4) -> {1, 2}.
